// File: rtl/ocidec2_pio_ctrl.sv
// ocidec2_pio_ctrl: PIO-only IDE host controller core.
// Register accesses use the compatible (cmdport) timing set. Data-register
// accesses (PIOa == 4'h0) use the fast timing of the device selected by the
// DEV bit last written to the Device/Head register.
// Optional build macro: OCIDEC2_IORDY_TIMEOUT_EN adds a bounded IORDY wait
// (TOWIDTH counter) and the PIOerr output.
module ocidec2_pio_ctrl #(
   parameter int TWIDTH  = 8
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
   ,
   parameter int TOWIDTH = 12
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IDEctrl_rst,
   input  logic              IDEctrl_IDEen,
   input  logic              IDEctrl_FATR0,
   input  logic              IDEctrl_FATR1,
   input  logic [TWIDTH-1:0] PIO_cmdport_T1,
   input  logic [TWIDTH-1:0] PIO_cmdport_T2,
   input  logic [TWIDTH-1:0] PIO_cmdport_T4,
   input  logic [TWIDTH-1:0] PIO_cmdport_Teoc,
   input  logic              PIO_cmdport_IORDYen,
   input  logic [TWIDTH-1:0] PIO_dport0_T1,
   input  logic [TWIDTH-1:0] PIO_dport0_T2,
   input  logic [TWIDTH-1:0] PIO_dport0_T4,
   input  logic [TWIDTH-1:0] PIO_dport0_Teoc,
   input  logic              PIO_dport0_IORDYen,
   input  logic [TWIDTH-1:0] PIO_dport1_T1,
   input  logic [TWIDTH-1:0] PIO_dport1_T2,
   input  logic [TWIDTH-1:0] PIO_dport1_T4,
   input  logic [TWIDTH-1:0] PIO_dport1_Teoc,
   input  logic              PIO_dport1_IORDYen,
   input  logic              PIOreq,
   output logic              PIOack,
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
   output logic              PIOerr,
`endif
   input  logic [3:0]        PIOa,
   input  logic [15:0]       PIOd,
   output logic [15:0]       PIOq,
   input  logic              PIOwe,
   output logic              irq,
   output logic              RESETn,
   input  logic [15:0]       DDi,
   output logic [15:0]       DDo,
   output logic              DDoe,
   output logic [2:0]        DA,
   output logic              CS0n,
   output logic              CS1n,
   output logic              DIORn,
   output logic              DIOWn,
   input  logic              IORDY,
   input  logic              INTRQ
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_WAIT,
      S_HOLD,
      S_RECOVER,
      S_ACK
   } state_t;

   // Phase counters are loaded with (length - 1); a programmed 0 behaves as 1.
   function automatic logic [TWIDTH-1:0] len_m1(input logic [TWIDTH-1:0] t);
      return (t == '0) ? '0 : t - TWIDTH'(1);
   endfunction

   state_t            state_q, state_d;
   logic [TWIDTH-1:0] cnt_q, cnt_d;
   logic [TWIDTH-1:0] t2_q, t2_d;
   logic [TWIDTH-1:0] t4_q, t4_d;
   logic [TWIDTH-1:0] teoc_q, teoc_d;
   logic              iordyen_q, iordyen_d;
   logic              we_q, we_d;
   logic [3:0]        a_q, a_d;
   logic [15:0]       ddo_q, ddo_d;
   logic              ddoe_q, ddoe_d;
   logic              dev_sel_q, dev_sel_d;
   logic [15:0]       pioq_q, pioq_d;
   logic              pioack_q, pioack_d;
   logic              ack_prev_q, ack_prev_d;
   logic              cs0n_q, cs0n_d;
   logic              cs1n_q, cs1n_d;
   logic              diorn_q, diorn_d;
   logic              diown_q, diown_d;
   logic              resetn_q, resetn_d;
   logic              iordy_s1_q, iordy_s1_d;
   logic              iordy_s2_q, iordy_s2_d;
   logic              intrq_s1_q, intrq_s1_d;
   logic              intrq_s2_q, intrq_s2_d;
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
   logic [TOWIDTH-1:0] to_cnt_q, to_cnt_d;
   logic               err_q, err_d;
   logic               pioerr_q, pioerr_d;
`endif

   logic              accept;
   logic              capture;
   logic              busy;
   logic              strobe;
   logic              use_fast;
   logic [TWIDTH-1:0] sel_t1, sel_t2, sel_t4, sel_teoc;
   logic              sel_iordyen;

   // New request is taken only in IDLE and never in the cycle right after an
   // ack, so a level request still high from the last transfer is ignored.
   assign accept = (state_q == S_IDLE) && PIOreq && !ack_prev_q;

   // Timing set selection from the current request and captured DEV bit.
   always_comb begin
      use_fast    = (PIOa == 4'h0) && (dev_sel_q ? IDEctrl_FATR1 : IDEctrl_FATR0);
      sel_t1      = PIO_cmdport_T1;
      sel_t2      = PIO_cmdport_T2;
      sel_t4      = PIO_cmdport_T4;
      sel_teoc    = PIO_cmdport_Teoc;
      sel_iordyen = PIO_cmdport_IORDYen;
      if (use_fast && !dev_sel_q) begin
         sel_t1      = PIO_dport0_T1;
         sel_t2      = PIO_dport0_T2;
         sel_t4      = PIO_dport0_T4;
         sel_teoc    = PIO_dport0_Teoc;
         sel_iordyen = PIO_dport0_IORDYen;
      end else if (use_fast && dev_sel_q) begin
         sel_t1      = PIO_dport1_T1;
         sel_t2      = PIO_dport1_T2;
         sel_t4      = PIO_dport1_T4;
         sel_teoc    = PIO_dport1_Teoc;
         sel_iordyen = PIO_dport1_IORDYen;
      end
   end

   // Next-state, phase counting, and bus outputs derived from the next state
   // so every pad output is a flop aligned with its FSM phase.
   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q != '0) ? cnt_q - TWIDTH'(1) : '0;
      t2_d       = t2_q;
      t4_d       = t4_q;
      teoc_d     = teoc_q;
      iordyen_d  = iordyen_q;
      we_d       = we_q;
      a_d        = a_q;
      ddo_d      = ddo_q;
      dev_sel_d  = dev_sel_q;
      pioq_d     = pioq_q;
      capture    = 1'b0;
      resetn_d   = !IDEctrl_rst;
      iordy_s1_d = IORDY;
      iordy_s2_d = iordy_s1_q;
      intrq_s1_d = INTRQ;
      intrq_s2_d = intrq_s1_q;
      ack_prev_d = pioack_q;
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
      to_cnt_d   = to_cnt_q;
      err_d      = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (accept) begin
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
               err_d = 1'b0;
`endif
               if (IDEctrl_IDEen) begin
                  state_d   = S_SETUP;
                  cnt_d     = len_m1(sel_t1);
                  t2_d      = len_m1(sel_t2);
                  t4_d      = len_m1(sel_t4);
                  teoc_d    = len_m1(sel_teoc);
                  iordyen_d = sel_iordyen;
                  we_d      = PIOwe;
                  a_d       = PIOa;
                  if (PIOwe) begin
                     ddo_d = PIOd;
                  end
                  if (PIOwe && (PIOa == 4'h6)) begin
                     dev_sel_d = PIOd[4];
                  end
               end else begin
                  // Disabled controller: complete the handshake with no bus cycle.
                  state_d = S_ACK;
               end
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_STROBE;
               cnt_d   = t2_q;
            end
         end
         S_STROBE: begin
            if (cnt_q == '0) begin
               if (iordyen_q && !iordy_s2_q) begin
                  state_d = S_WAIT;
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
                  to_cnt_d = TOWIDTH'(1);
`endif
               end else begin
                  state_d = S_HOLD;
                  cnt_d   = t4_q;
                  capture = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (iordy_s2_q) begin
               state_d = S_HOLD;
               cnt_d   = t4_q;
               capture = 1'b1;
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
            end else if (to_cnt_q == '1) begin
               // Device never released IORDY: finish the cycle, flag an error.
               state_d = S_HOLD;
               cnt_d   = t4_q;
               err_d   = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TOWIDTH'(1);
`endif
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_RECOVER;
               cnt_d   = teoc_q;
            end
         end
         S_RECOVER: begin
            if (cnt_q == '0) begin
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (capture && !we_q) begin
         pioq_d = DDi;
      end

      busy     = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_WAIT) ||
                 (state_d == S_HOLD) || (state_d == S_RECOVER);
      strobe   = (state_d == S_STROBE) || (state_d == S_WAIT);
      cs0n_d   = !(busy && !a_d[3]);
      cs1n_d   = !(busy && a_d[3]);
      diorn_d  = !(strobe && !we_d);
      diown_d  = !(strobe && we_d);
      ddoe_d   = we_d && ((state_d == S_SETUP) || (state_d == S_STROBE) ||
                          (state_d == S_WAIT) || (state_d == S_HOLD));
      pioack_d = (state_d == S_ACK);
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
      pioerr_d = (state_d == S_ACK) && err_d;
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         t2_q       <= '0;
         t4_q       <= '0;
         teoc_q     <= '0;
         iordyen_q  <= 1'b0;
         we_q       <= 1'b0;
         a_q        <= '0;
         ddo_q      <= '0;
         ddoe_q     <= 1'b0;
         dev_sel_q  <= 1'b0;
         pioq_q     <= '0;
         pioack_q   <= 1'b0;
         ack_prev_q <= 1'b0;
         cs0n_q     <= 1'b1;
         cs1n_q     <= 1'b1;
         diorn_q    <= 1'b1;
         diown_q    <= 1'b1;
         resetn_q   <= 1'b0;
         iordy_s1_q <= 1'b0;
         iordy_s2_q <= 1'b0;
         intrq_s1_q <= 1'b0;
         intrq_s2_q <= 1'b0;
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
         to_cnt_q   <= '0;
         err_q      <= 1'b0;
         pioerr_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         t2_q       <= t2_d;
         t4_q       <= t4_d;
         teoc_q     <= teoc_d;
         iordyen_q  <= iordyen_d;
         we_q       <= we_d;
         a_q        <= a_d;
         ddo_q      <= ddo_d;
         ddoe_q     <= ddoe_d;
         dev_sel_q  <= dev_sel_d;
         pioq_q     <= pioq_d;
         pioack_q   <= pioack_d;
         ack_prev_q <= ack_prev_d;
         cs0n_q     <= cs0n_d;
         cs1n_q     <= cs1n_d;
         diorn_q    <= diorn_d;
         diown_q    <= diown_d;
         resetn_q   <= resetn_d;
         iordy_s1_q <= iordy_s1_d;
         iordy_s2_q <= iordy_s2_d;
         intrq_s1_q <= intrq_s1_d;
         intrq_s2_q <= intrq_s2_d;
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
         err_q      <= err_d;
         pioerr_q   <= pioerr_d;
`endif
      end
   end

   assign PIOack = pioack_q;
   assign PIOq   = pioq_q;
   assign irq    = intrq_s2_q;
   assign RESETn = resetn_q;
   assign DDo    = ddo_q;
   assign DDoe   = ddoe_q;
   assign DA     = a_q[2:0];
   assign CS0n   = cs0n_q;
   assign CS1n   = cs1n_q;
   assign DIORn  = diorn_q;
   assign DIOWn  = diown_q;
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
   assign PIOerr = pioerr_q;
`endif

endmodule

// File: tb/tb_ocidec2_pio_ctrl.sv
// Self-checking bench for ocidec2_pio_ctrl: table of directed transfers plus
// hand-written sequences for IORDY wait, disable, reset mid-transfer and
// (with OCIDEC2_IORDY_TIMEOUT_EN) the IORDY timeout.
module tb_ocidec2_pio_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        IDEctrl_rst, IDEctrl_IDEen, IDEctrl_FATR0, IDEctrl_FATR1;
   logic [7:0]  cmd_t1, cmd_t2, cmd_t4, cmd_teoc;
   logic        cmd_iordyen;
   logic [7:0]  dp0_t1, dp0_t2, dp0_t4, dp0_teoc;
   logic        dp0_iordyen;
   logic [7:0]  dp1_t1, dp1_t2, dp1_t4, dp1_teoc;
   logic        dp1_iordyen;
   logic        PIOreq, PIOack, PIOwe, irq, RESETn;
   logic [3:0]  PIOa;
   logic [15:0] PIOd, PIOq, DDi, DDo;
   logic        DDoe, CS0n, CS1n, DIORn, DIOWn, IORDY, INTRQ;
   logic [2:0]  DA;
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
   logic        PIOerr;
`endif

   always #5 clk = ~clk;

   ocidec2_pio_ctrl #(
      .TWIDTH(8)
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
      ,
      .TOWIDTH(4)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .IDEctrl_rst(IDEctrl_rst), .IDEctrl_IDEen(IDEctrl_IDEen),
      .IDEctrl_FATR0(IDEctrl_FATR0), .IDEctrl_FATR1(IDEctrl_FATR1),
      .PIO_cmdport_T1(cmd_t1), .PIO_cmdport_T2(cmd_t2), .PIO_cmdport_T4(cmd_t4),
      .PIO_cmdport_Teoc(cmd_teoc), .PIO_cmdport_IORDYen(cmd_iordyen),
      .PIO_dport0_T1(dp0_t1), .PIO_dport0_T2(dp0_t2), .PIO_dport0_T4(dp0_t4),
      .PIO_dport0_Teoc(dp0_teoc), .PIO_dport0_IORDYen(dp0_iordyen),
      .PIO_dport1_T1(dp1_t1), .PIO_dport1_T2(dp1_t2), .PIO_dport1_T4(dp1_t4),
      .PIO_dport1_Teoc(dp1_teoc), .PIO_dport1_IORDYen(dp1_iordyen),
      .PIOreq(PIOreq), .PIOack(PIOack),
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
      .PIOerr(PIOerr),
`endif
      .PIOa(PIOa), .PIOd(PIOd), .PIOq(PIOq), .PIOwe(PIOwe), .irq(irq),
      .RESETn(RESETn), .DDi(DDi), .DDo(DDo), .DDoe(DDoe), .DA(DA),
      .CS0n(CS0n), .CS1n(CS1n), .DIORn(DIORn), .DIOWn(DIOWn),
      .IORDY(IORDY), .INTRQ(INTRQ)
   );

   typedef struct {
      logic [3:0]  a;
      logic        we;
      logic [15:0] d;
      logic [15:0] ddi;
      logic        en;
      logic        fatr0;
      int          lat;
      int          cs_cnt;
      int          str_first;
      int          str_cnt;
      int          oe_cnt;
      logic [15:0] q;
   } vec_t;

   vec_t vecs [11];

   int n_cmp = 0;
   int n_bad = 0;

   // Observations from the most recent run_xfer call.
   int          o_lat, o_cs0_first, o_cs0_cnt, o_cs1_first, o_cs1_cnt;
   int          o_rd_first, o_rd_cnt, o_wr_first, o_wr_cnt, o_oe_cnt;
   logic [15:0] o_ddo, o_q;
   logic [2:0]  o_da;
   logic        o_err;

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0d (0x%0h) expected %0d (0x%0h)", name, idx, act, act, exp, exp);
      end
   endtask

   // Called just after a posedge (that cycle is cycle 0, the acceptance
   // cycle). Watches the bus each cycle until PIOack or a cycle budget.
   task automatic run_xfer(input int release_at);
      o_lat = -1; o_cs0_first = -1; o_cs0_cnt = 0; o_cs1_first = -1; o_cs1_cnt = 0;
      o_rd_first = -1; o_rd_cnt = 0; o_wr_first = -1; o_wr_cnt = 0; o_oe_cnt = 0;
      o_ddo = '0; o_q = '0; o_da = '0; o_err = 1'b0;
      PIOreq = 1'b1;
      for (int n = 1; n <= 200 && o_lat < 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (!CS0n) begin
            if (o_cs0_first < 0) begin o_cs0_first = n; o_da = DA; end
            o_cs0_cnt++;
         end
         if (!CS1n) begin
            if (o_cs1_first < 0) begin o_cs1_first = n; o_da = DA; end
            o_cs1_cnt++;
         end
         if (!DIORn) begin
            if (o_rd_first < 0) o_rd_first = n;
            o_rd_cnt++;
         end
         if (!DIOWn) begin
            if (o_wr_first < 0) o_wr_first = n;
            o_wr_cnt++;
            o_ddo = DDo;
         end
         if (DDoe) o_oe_cnt++;
         if (n == release_at) IORDY = 1'b1;
         if (PIOack) begin
            o_lat = n;
            o_q   = PIOq;
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
            o_err = PIOerr;
`endif
         end
      end
      @(posedge clk);
      #1 PIOreq = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_seen;
      int cs_seen;
      // a    we    d        ddi      en    fatr0 lat cs  sf  sc  oe  q
      vecs[0]  = '{4'h7, 1'b0, 16'h0000, 16'hA5C3, 1'b1, 1'b1, 11, 10,  3,  4,  0, 16'hA5C3};
      vecs[1]  = '{4'h7, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1,  1,  0, -1,  0,  0, 16'hA5C3};
      vecs[2]  = '{4'h0, 1'b0, 16'h0000, 16'h5A5A, 1'b1, 1'b1,  9,  8,  4,  2,  0, 16'h5A5A};
      vecs[3]  = '{4'h6, 1'b1, 16'h0010, 16'h0000, 1'b1, 1'b1, 11, 10,  3,  4,  7, 16'h5A5A};
      vecs[4]  = '{4'h0, 1'b1, 16'h1234, 16'h0000, 1'b1, 1'b1,  5,  4,  2,  1,  3, 16'h5A5A};
      vecs[5]  = '{4'hE, 1'b0, 16'h0000, 16'hC001, 1'b1, 1'b1, 11, 10,  3,  4,  0, 16'hC001};
      vecs[6]  = '{4'h0, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b1,  5,  4,  2,  1,  0, 16'hBEEF};
      vecs[7]  = '{4'h6, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 11, 10,  3,  4,  7, 16'hBEEF};
      vecs[8]  = '{4'h0, 1'b0, 16'h0000, 16'h0F0F, 1'b1, 1'b1,  9,  8,  4,  2,  0, 16'h0F0F};
      vecs[9]  = '{4'h0, 1'b0, 16'h0000, 16'h1111, 1'b1, 1'b0, 11, 10,  3,  4,  0, 16'h1111};
      vecs[10] = '{4'h0, 1'b1, 16'hABCD, 16'h0000, 1'b1, 1'b0, 11, 10,  3,  4,  7, 16'h1111};

      rst = 1'b1; IDEctrl_rst = 1'b1; IDEctrl_IDEen = 1'b1;
      IDEctrl_FATR0 = 1'b1; IDEctrl_FATR1 = 1'b1;
      cmd_t1 = 8'd2; cmd_t2 = 8'd4; cmd_t4 = 8'd1; cmd_teoc = 8'd3; cmd_iordyen = 1'b0;
      dp0_t1 = 8'd3; dp0_t2 = 8'd2; dp0_t4 = 8'd2; dp0_teoc = 8'd0; dp0_iordyen = 1'b0;
      dp1_t1 = 8'd1; dp1_t2 = 8'd1; dp1_t4 = 8'd1; dp1_teoc = 8'd1; dp1_iordyen = 1'b0;
      PIOreq = 1'b0; PIOa = 4'h0; PIOd = 16'h0; PIOwe = 1'b0;
      DDi = 16'h0; IORDY = 1'b1; INTRQ = 1'b0;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_RESETn", 0, int'(RESETn), 0);
      chk("rst_DIORn",  0, int'(DIORn), 1);
      chk("rst_DIOWn",  0, int'(DIOWn), 1);
      chk("rst_CS0n",   0, int'(CS0n), 1);
      chk("rst_CS1n",   0, int'(CS1n), 1);
      chk("rst_DA",     0, int'(DA), 0);
      chk("rst_DDo",    0, int'(DDo), 0);
      chk("rst_DDoe",   0, int'(DDoe), 0);
      chk("rst_PIOack", 0, int'(PIOack), 0);
      chk("rst_PIOq",   0, int'(PIOq), 0);
      chk("rst_irq",    0, int'(irq), 0);
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
      chk("rst_PIOerr", 0, int'(PIOerr), 0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("resetn_held", 0, int'(RESETn), 0);
      @(posedge clk);
      #1 IDEctrl_rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("resetn_release", 0, int'(RESETn), 1);

      // INTRQ passes through two flops.
      @(posedge clk);
      #1 INTRQ = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("irq_stage1", 0, int'(irq), 0);
      @(posedge clk);
      @(negedge clk);
      chk("irq_stage2", 0, int'(irq), 1);

      // Table-driven transfers.
      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) begin
         int a_first, a_cnt, o_cnt, s_first, s_cnt, so_cnt;
         PIOa = vecs[i].a; PIOwe = vecs[i].we; PIOd = vecs[i].d; DDi = vecs[i].ddi;
         IDEctrl_IDEen = vecs[i].en; IDEctrl_FATR0 = vecs[i].fatr0;
         run_xfer(-1);
         a_first = vecs[i].a[3] ? o_cs1_first : o_cs0_first;
         a_cnt   = vecs[i].a[3] ? o_cs1_cnt   : o_cs0_cnt;
         o_cnt   = vecs[i].a[3] ? o_cs0_cnt   : o_cs1_cnt;
         s_first = vecs[i].we ? o_wr_first : o_rd_first;
         s_cnt   = vecs[i].we ? o_wr_cnt   : o_rd_cnt;
         so_cnt  = vecs[i].we ? o_rd_cnt   : o_wr_cnt;
         $display("xfer %0d: a=%h we=%b en=%b lat=%0d cs=%0d strobe=%0d@%0d oe=%0d q=%h",
                  i, vecs[i].a, vecs[i].we, vecs[i].en, o_lat, a_cnt, s_cnt, s_first, o_oe_cnt, o_q);
         chk("lat",       i, o_lat, vecs[i].lat);
         chk("cs_first",  i, a_first, vecs[i].en ? 1 : -1);
         chk("cs_cnt",    i, a_cnt, vecs[i].cs_cnt);
         chk("cs_other",  i, o_cnt, 0);
         chk("str_first", i, s_first, vecs[i].str_first);
         chk("str_cnt",   i, s_cnt, vecs[i].str_cnt);
         chk("str_other", i, so_cnt, 0);
         chk("oe_cnt",    i, o_oe_cnt, vecs[i].oe_cnt);
         chk("pioq",      i, int'(o_q), int'(vecs[i].q));
         if (vecs[i].en) chk("da", i, int'(o_da), int'(vecs[i].a[2:0]));
         if (vecs[i].en && vecs[i].we) chk("ddo", i, int'(o_ddo), int'(vecs[i].d));
      end
      IDEctrl_IDEen = 1'b1; IDEctrl_FATR0 = 1'b1;

      // IORDY low across the end of STROBE: six WAIT cycles (7..12).
      PIOa = 4'h7; PIOwe = 1'b0; DDi = 16'h3C3C; cmd_iordyen = 1'b1; IORDY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      run_xfer(10);
      $display("xfer iordy_wait: lat=%0d dior=%0d q=%h", o_lat, o_rd_cnt, o_q);
      chk("wait_lat",      0, o_lat, 17);
      chk("wait_dior_cnt", 0, o_rd_cnt, 10);
      chk("wait_dior_1st", 0, o_rd_first, 3);
      chk("wait_lat_rel",  0, o_lat, 11 + (o_rd_cnt - 4));
      chk("wait_cs_cnt",   0, o_cs0_cnt, 16);
      chk("wait_pioq",     0, int'(o_q), 16'h3C3C);
`ifdef OCIDEC2_IORDY_TIMEOUT_EN
      chk("wait_err",      0, int'(o_err), 0);
`endif

      // IORDYen set but IORDY already high: no WAIT.
      DDi = 16'h4242;
      run_xfer(-1);
      $display("xfer iordy_ready: lat=%0d dior=%0d q=%h", o_lat, o_rd_cnt, o_q);
      chk("ready_lat",  0, o_lat, 11);
      chk("ready_dior", 0, o_rd_cnt, 4);
      chk("ready_pioq", 0, int'(o_q), 16'h4242);
      cmd_iordyen = 1'b0;

      // rst during STROBE: bus released at the next edge, no ack afterwards.
      PIOa = 4'h7; PIOwe = 1'b0; PIOreq = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rstx_strobe_on", 0, int'(DIORn), 0);
      rst = 1'b1;
      @(posedge clk);
      #1 PIOreq = 1'b0;
      @(negedge clk);
      chk("rstx_DIORn",  0, int'(DIORn), 1);
      chk("rstx_CS0n",   0, int'(CS0n), 1);
      chk("rstx_PIOack", 0, int'(PIOack), 0);
      chk("rstx_PIOq",   0, int'(PIOq), 0);
      chk("rstx_RESETn", 0, int'(RESETn), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      ack_seen = 0;
      cs_seen = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (PIOack) ack_seen++;
         if (!CS0n || !CS1n) cs_seen++;
      end
      $display("xfer rst_mid: acks=%0d cs_cycles=%0d", ack_seen, cs_seen);
      chk("rstx_no_ack", 0, ack_seen, 0);
      chk("rstx_no_cs",  0, cs_seen, 0);
      @(posedge clk);
      #1;

`ifdef OCIDEC2_IORDY_TIMEOUT_EN
      // IORDY stuck low: 15 WAIT cycles, then HOLD and RECOVER, ack with error.
      PIOa = 4'h7; PIOwe = 1'b0; DDi = 16'h7777; cmd_iordyen = 1'b1; IORDY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      run_xfer(-1);
      $display("xfer iordy_timeout: lat=%0d dior=%0d err=%b q=%h", o_lat, o_rd_cnt, o_err, o_q);
      chk("to_lat",  0, o_lat, 26);
      chk("to_dior", 0, o_rd_cnt, 19);
      chk("to_err",  0, int'(o_err), 1);
      chk("to_pioq", 0, int'(o_q), 0);
      IORDY = 1'b1;
      cmd_iordyen = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ocidec2_pio_ctrl.md
Name: ocidec2_pio_ctrl

Overview:
Second-generation PIO-only IDE host controller core with a self-contained PIO timing state machine. Command and control register accesses use one compatible timing set. Data-register accesses (PIOa=4'h0) use per-device fast timing, selected by the DEV bit last written to the Device/Head register. The block sits between the host register/handshake logic and the ATA bus pads.

Parameters:
TWIDTH, 8, width of every timing field and of the phase counter.
TOWIDTH, 12, width of the IORDY timeout counter (used only with the optional feature).

Ports:
clk  in  1  master clock
rst  in  1  synchronous active-high reset
IDEctrl_rst  in  1  drive ATA RESETn low while 1
IDEctrl_IDEen  in  1  controller enable
IDEctrl_FATR0  in  1  fast timing enable, device 0
IDEctrl_FATR1  in  1  fast timing enable, device 1
PIO_cmdport_T1/T2/T4/Teoc  in  TWIDTH each  compatible timing (cycles)
PIO_cmdport_IORDYen  in  1  compatible-timing IORDY enable
PIO_dport0_T1/T2/T4/Teoc  in  TWIDTH each  device-0 fast timing
PIO_dport0_IORDYen  in  1
PIO_dport1_T1/T2/T4/Teoc  in  TWIDTH each  device-1 fast timing
PIO_dport1_IORDYen  in  1
PIOreq  in  1  transfer request, level, held until PIOack
PIOack  out  1  one-cycle completion pulse
PIOa  in  4  [3]=CS1 select, [2:0]=DA
PIOd  in  16  write data
PIOq  out  16  read data
PIOwe  in  1  1=write, 0=read
irq  out  1  synchronized INTRQ
RESETn, DDo[16], DDoe, DA[3], CS0n, CS1n, DIORn, DIOWn  out  ATA bus, all registered
DDi  in  16;  IORDY  in  1;  INTRQ  in  1

Behaviour:
- Reset: this block has one clock (clk) and a synchronous active-high reset (rst); nothing in it is reset asynchronously.
- Reset values: RESETn=0, DIORn=DIOWn=CS0n=CS1n=1, DA=0, DDo=0, DDoe=0, PIOack=0, PIOq=0, irq=0, dev_sel=0, FSM=IDLE.
- IORDY and INTRQ each pass through a 2-flop synchronizer. irq is the second INTRQ stage.
- RESETn is a registered !IDEctrl_rst and is independent of the FSM.
- Timing select, latched when a transfer is accepted:
  - use dport[dev_sel] when PIOa==4'h0 and FATR[dev_sel]=1;
  - otherwise use the cmdport timing.
  - A field value of 0 is treated as 1.
- dev_sel capture: on acceptance of a write with PIOa==4'h6, dev_sel<=PIOd[4]. The captured value applies from the next transfer.
- Acceptance: in IDLE, PIOreq=1, and PIOack not asserted in the previous cycle.
  - If IDEctrl_IDEen=0: PIOack pulses in the next cycle, there is no bus activity, and PIOq is unchanged.
  - If IDEctrl_IDEen=1: the FSM enters SETUP.
- FSM IDLE->SETUP(T1)->STROBE(T2)->[WAIT]->HOLD(T4)->RECOVER(Teoc)->ACK->IDLE. Phase counter loaded on entry; phase lasts N cycles.
- CS0n/CS1n and DA: CS0n=!(~PIOa[3]), CS1n=!PIOa[3]. Valid from the first SETUP cycle through the last RECOVER cycle. Deasserted in ACK.
- DIORn/DIOWn: low during STROBE and WAIT only, per PIOwe.
- Writes: DDo=PIOd and DDoe=1 from SETUP through HOLD. DDoe=0 from RECOVER on.
- IORDY: on the last STROBE cycle, if the selected IORDYen=1 and synchronized IORDY=0, go to WAIT. Hold WAIT while IORDY=0; go to HOLD the cycle after IORDY=1 is seen.
- Reads: PIOq<=DDi on the final strobe cycle (last STROBE cycle, or the last WAIT cycle).
- ACK: PIOack=1 for exactly one cycle. Latency from the acceptance cycle = T1+T2+T4+Teoc+1 + wait cycles.
- IDEctrl_IDEen falling mid-transfer: the current transfer completes normally.
- rst mid-transfer: FSM returns to IDLE, the bus is released at the next edge, no PIOack.
- Timing inputs changing mid-transfer do not affect the transfer in progress.

Optional Feature:
Macro: OCIDEC2_IORDY_TIMEOUT_EN.
- When defined:
  - adds output PIOerr (1 bit, reset 0);
  - WAIT counts cycles in a TOWIDTH counter;
  - if the counter reaches all-ones, the FSM goes to HOLD, PIOq is not updated, and PIOerr=1 in the same cycle as PIOack.
- When undefined: there is no PIOerr port and WAIT is unbounded.

Test Plan:
1. Reset, then 3 idle cycles → all outputs at their reset values; RESETn=1 once IDEctrl_rst=0.
2. Read with cmdport T1=2, T2=4, T4=1, Teoc=3, IORDYen=0, PIOa=4'h7, DDi=16'hA5C3, request accepted at cycle 0 →
   - CS0n low on cycles 1-10;
   - DIORn low on cycles 3-6;
   - PIOack on cycle 11 with PIOq=16'hA5C3.
3. Write to PIOa=4'h6 with PIOd[4]=1, FATR1=1, dport1 T1=T2=T4=Teoc=1, then a write to PIOa=4'h0 with PIOd=16'h1234 →
   - second transfer: DIOWn low for 1 cycle, DDo=16'h1234, DDoe high for 3 cycles;
   - PIOack 5 cycles after acceptance.
4. Same read as case 2 with IORDYen=1 and IORDY held low for 6 cycles over the strobe end → DIORn extended, and PIOack delayed by exactly the observed WAIT count.
5. IDEctrl_IDEen=0, PIOreq=1 → PIOack the next cycle, CS0n/CS1n stay 1. Then rst asserted during STROBE of an enabled transfer → bus released the next cycle, no PIOack.
6. With OCIDEC2_IORDY_TIMEOUT_EN, TOWIDTH=4, IORDY stuck low → PIOack and PIOerr pulse together after 15 WAIT cycles plus HOLD and RECOVER; PIOq unchanged.
